// File: rtl/wb_pkg.sv
// Shared types and sizing for the writeback arbiter and its long-latency FIFO.
package wb_pkg;

   localparam int unsigned WB_DEPTH = 4;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned NREGS    = 2 ** REG_W;
   localparam int unsigned WB_PTR_W = $clog2(WB_DEPTH);
   localparam int unsigned WB_CNT_W = WB_PTR_W + 1;

   // One queued long-latency result; live=0 means accepted but never written.
   typedef struct packed {
      logic              live;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // Pointer width for a power-of-two FIFO depth.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency results with kill-by-rd and a pending bitmap.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 push,
   input  wb_entry_t            push_entry,
   input  logic                 pop,
   input  logic [1:0]           kill_en,
   input  logic [2*REG_W-1:0]   kill_rd,
   output wb_entry_t            head_c,
   output logic                 empty_c,
   output logic                 full_c,
   output logic [NREGS-1:0]     pending_c
);

   localparam int unsigned PTR_W = ptr_w(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t          mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [DEPTH-1:0]   kill_c;

   // Per-slot kill: a live slot dies when an active lane writes the same rd.
   always_comb begin
      kill_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         kill_c[i] = mem[i].live &&
                     ((kill_en[0] && (mem[i].rd == kill_rd[REG_W-1:0])) ||
                      (kill_en[1] && (mem[i].rd == kill_rd[2*REG_W-1:REG_W])));
      end
   end

   // Storage, pointers and occupancy; popped slots are left dead.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_c[i] || (pop && (rd_ptr == PTR_W'(i)))) begin
               mem[i].live <= 1'b0;
            end
         end
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head_c  = mem[rd_ptr];
   assign empty_c = (count == '0);
   assign full_c  = (count == CNT_W'(DEPTH));

   // Registers still owed a write by a live queued entry; x0 never pending.
   always_comb begin
      pending_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i].live) begin
            pending_c[mem[i].rd] = 1'b1;
         end
      end
      pending_c[0] = 1'b0;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Merges two ALU lanes and queued long-latency results onto two register-file write ports.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              en,
   input  logic              alu0_valid,
   input  logic [REG_W-1:0]  alu0_rd,
   input  logic [DATA_W-1:0] alu0_data,
   input  logic              alu1_valid,
   input  logic [REG_W-1:0]  alu1_rd,
   input  logic [DATA_W-1:0] alu1_data,
   input  logic              ll_valid,
   output logic              ll_ready,
   input  logic [REG_W-1:0]  ll_rd,
   input  logic [DATA_W-1:0] ll_data,
   output logic              reg_write,
   output logic [REG_W-1:0]  regd,
   output logic [DATA_W-1:0] write_data,
   output logic              reg_write2,
   output logic [REG_W-1:0]  regd2,
   output logic [DATA_W-1:0] write_data2,
   output logic [NREGS-1:0]  pending
);

   logic              lane0_act_c;
   logic              lane1_act_c;
   logic              ll_hit_c;
   logic              head_hit_c;
   logic              head_live_c;
   logic              issue1_c;
   logic              issue2_c;
   logic              pop_c;
   logic              push_c;
   logic              empty_c;
   logic              full_c;
   wb_entry_t         head_c;
   wb_entry_t         push_entry_c;
   logic [NREGS-1:0]  pending_c;

   logic              we1_nxt;
   logic [REG_W-1:0]  rd1_nxt;
   logic [DATA_W-1:0] d1_nxt;
   logic              we2_nxt;
   logic [REG_W-1:0]  rd2_nxt;
   logic [DATA_W-1:0] d2_nxt;

   // Lane activity, WAW hits, head disposition and next port contents.
   always_comb begin
      lane0_act_c = alu0_valid && (alu0_rd != '0);
      lane1_act_c = alu1_valid && (alu1_rd != '0);

      ll_hit_c   = en && ((lane0_act_c && (ll_rd == alu0_rd)) ||
                          (lane1_act_c && (ll_rd == alu1_rd)));
      head_hit_c = (lane0_act_c && (head_c.rd == alu0_rd)) ||
                   (lane1_act_c && (head_c.rd == alu1_rd));

      head_live_c = !empty_c && head_c.live && !head_hit_c;
      issue1_c    = head_live_c && !lane0_act_c;
      issue2_c    = head_live_c && lane0_act_c && !lane1_act_c;
      // Dead or just-killed heads leave without consuming a port.
      pop_c       = en && !empty_c && (!head_live_c || issue1_c || issue2_c);
      push_c      = ll_valid && !full_c;

      push_entry_c.live = (ll_rd != '0) && !ll_hit_c;
      push_entry_c.rd   = ll_rd;
      push_entry_c.data = ll_data;

      we1_nxt = 1'b0;
      rd1_nxt = '0;
      d1_nxt  = '0;
      we2_nxt = 1'b0;
      rd2_nxt = '0;
      d2_nxt  = '0;
      if (lane0_act_c) begin
         we1_nxt = 1'b1;
         rd1_nxt = alu0_rd;
         d1_nxt  = alu0_data;
      end else if (issue1_c) begin
         we1_nxt = 1'b1;
         rd1_nxt = head_c.rd;
         d1_nxt  = head_c.data;
      end
      if (lane1_act_c) begin
         we2_nxt = 1'b1;
         rd2_nxt = alu1_rd;
         d2_nxt  = alu1_data;
      end else if (issue2_c) begin
         we2_nxt = 1'b1;
         rd2_nxt = head_c.rd;
         d2_nxt  = head_c.data;
      end
   end

   // Write-port registers advance only with the pipeline.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         reg_write   <= 1'b0;
         regd        <= '0;
         write_data  <= '0;
         reg_write2  <= 1'b0;
         regd2       <= '0;
         write_data2 <= '0;
      end else if (en) begin
         reg_write   <= we1_nxt;
         regd        <= rd1_nxt;
         write_data  <= d1_nxt;
         reg_write2  <= we2_nxt;
         regd2       <= rd2_nxt;
         write_data2 <= d2_nxt;
      end
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .n_rst      (n_rst),
      .push       (push_c),
      .push_entry (push_entry_c),
      .pop        (pop_c),
      .kill_en    ({en && lane1_act_c, en && lane0_act_c}),
      .kill_rd    ({alu1_rd, alu0_rd}),
      .head_c     (head_c),
      .empty_c    (empty_c),
      .full_c     (full_c),
      .pending_c  (pending_c)
   );

   assign ll_ready = !full_c;
   assign pending  = pending_c;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter driving the two write ports of the dual-issue register file. Each cycle it merges the two in-order ALU lanes with results from a long-latency unit (load/mul-div). Long-latency results sit in a small FIFO until a write port is free. Queued results are killed when a younger ALU write targets the same register (WAW), and the block exports a pending-register bitmap for the issue scoreboard.

## Interface
Parameters:
- DEPTH, 4, long-latency FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  clock
- n_rst  input  1  asynchronous active-low reset
- en  input  1  pipeline advance; same signal as the register file's en
- alu0_valid  input  1  lane 0 result valid
- alu0_rd  input  5  lane 0 destination
- alu0_data  input  32  lane 0 result
- alu1_valid  input  1  lane 1 (younger) result valid
- alu1_rd  input  5  lane 1 destination
- alu1_data  input  32  lane 1 result
- ll_valid  input  1  long-latency result offered
- ll_ready  output  1  FIFO can accept (count < DEPTH)
- ll_rd  input  5  long-latency destination
- ll_data  input  32  long-latency result
- reg_write  output  1  write port 1 enable
- regd  output  5  write port 1 destination
- write_data  output  32  write port 1 data
- reg_write2  output  1  write port 2 enable
- regd2  output  5  write port 2 destination
- write_data2  output  32  write port 2 data
- pending  output  32  bit r set while a live FIFO entry targets xr; bit 0 always 0

## Operation
- Reset: all write-port outputs 0, FIFO empty, ll_ready=1, pending=0.
- Lane mapping, sampled on edge when en=1: lane 0 → port 1, lane 1 → port 2. Lane write is active if valid && rd!=0. Inactive port drives reg_write=0, regd=0, data=0.
- Enqueue: ll_valid && ll_ready accepts on the edge, independent of en. Entry is stored live unless rd==0, or en=1 and an active lane this cycle has the same rd. In those cases the entry is stored dead (accepted, never written).
- Kill: on an en=1 edge, every live FIFO entry whose rd matches an active lane rd becomes dead.
- Drain, at most one per en=1 edge, taken from the head only:
  - Dead head: popped, consumes no port.
  - Live head, lane 0 inactive: issued on port 1.
  - Live head, lane 0 active and lane 1 inactive: issued on port 2.
  - Both lanes active: head waits.
  - A live head whose rd matches an active lane this cycle is killed, not issued.
- en=0: outputs hold their previous values, no drain, no kill; enqueue continues.
- Enqueue and drain in the same cycle: count unchanged. A full FIFO may accept only when ll_ready=1, so no same-cycle accept when full.
- pending is combinational from the FIFO live bits. Duplicate rd values OR together.

## Timing
- ALU lane: sampled at edge E, visible on ports after E; register file writes at E+1.
- Long-latency, empty FIFO, free port: accepted at E, issued at E+1, register file writes at E+2. There is no bypass.
- pending[r] rises the cycle after acceptance. It falls the cycle after the entry is issued or killed.
- ll_ready deasserts the cycle after the FIFO fills and reasserts the cycle after a pop.
- Reset mid-operation: FIFO contents and in-flight outputs are discarded immediately.

## Structure
- Package wb_pkg: DEPTH default, the wb_entry_t struct (live, rd[4:0], data[31:0]), and the pointer/count width derived from DEPTH.
- Sub-module wb_fifo: circular buffer of wb_entry_t with push/pop, count, and a per-entry kill-by-rd input vector that clears live bits. wb_arbiter holds the port-select logic and the output registers.

## Test plan
- Reset: assert n_rst=0 mid-traffic → all outputs 0, ll_ready=1, pending=0x00000000.
- Dual lane: en=1, lane 0 writes x5=0x11, lane 1 writes x6=0x22 → next cycle reg_write=1/regd=5/write_data=0x11 and reg_write2=1/regd2=6/write_data2=0x22.
- Blocked drain: ll x7=0xDEAD while both lanes are active for 3 cycles → no write of x7, pending=0x80. Lanes then idle → port 1 writes x7=0xDEAD, and pending=0 the cycle after.
- Full FIFO: 4 ll accepts with both lanes busy → ll_ready=0 and a fifth offer is held. One drain → ll_ready=1 the next cycle and the fifth is accepted.
- WAW kill: queue x9=0xAAAA, then lane 0 writes x9=0xBBBB → only 0xBBBB ever reaches a port, the dead entry pops without a write, pending[9]=0.
- Edge cases: ll rd=0 → accepted, never written, pending=0. en=0 for 2 cycles → ports hold, FIFO does not drain, accepts still occur.
